// File: rtl/lpc_uart_pkg.sv
// lpc_uart_pkg: shared constants and types for the LPC-attached UART.
//   - register offsets relative to the I/O base
//   - LPC cycle-type, START and SYNC nibble codes
//   - Line Status Register bit positions and a helper that assembles it
//   - state enums for the LPC cycle FSM and the bit-level receiver
package lpc_uart_pkg;

  localparam logic [2:0] OFS_DATA = 3'd0;
  localparam logic [2:0] OFS_LSR  = 3'd5;
  localparam logic [2:0] OFS_SCR  = 3'd7;

  localparam logic [3:0] LAD_START  = 4'h0;
  localparam logic [3:0] CTDIR_IORD = 4'h0;
  localparam logic [3:0] CTDIR_IOWR = 4'h2;
  localparam logic [3:0] SYNC_READY = 4'h0;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [2:0] {
    IDLE, CTDIR, ADDR, WDATA, TAR, SYNC, RDATA
  } lpc_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  // THRE and TEMT are identical: the transmitter has one slot and no shifter
  // separate from it.
  function automatic logic [7:0] lsr_value(input logic data_ready, input logic tx_idle);
    logic [7:0] v;
    v           = 8'h00;
    v[LSR_DR]   = data_ready;
    v[LSR_THRE] = tx_idle;
    v[LSR_TEMT] = tx_idle;
    return v;
  endfunction

endpackage

// File: rtl/lpc_uart_rx.sv
// lpc_uart_rx: bit-level UART receiver (8 data bits, LSB first, 1 stop bit).
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   rx_i     : raw serial input, idle high
//   data_o   : received byte, valid while valid_o is high
//   valid_o  : one-cycle strobe for a byte whose stop bit sampled high
// BAUD_DIV is the clock count per bit. The start bit is re-checked half a
// bit after the falling edge; every later bit is sampled at its middle.
module lpc_uart_rx
  import lpc_uart_pkg::*;
#(
  parameter int BAUD_DIV = 286
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int BW   = $clog2(BAUD_DIV + 1);
  localparam int HALF = BAUD_DIV / 2;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchroniser flops reset to the idle level so leaving reset never looks like a start edge.
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      valid_o   <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= RX_START;
            baud_q  <= '0;
          end
        end
        RX_START: begin
          if (baud_q == BW'(HALF - 1)) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_q == BW'(BAUD_DIV - 1)) begin
            baud_q  <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_q == BW'(BAUD_DIV - 1)) begin
            // Back to idle at mid-stop so a following start edge is not missed.
            baud_q  <= '0;
            state_q <= RX_IDLE;
            if (rx_sync_q) begin
              data_o  <= shift_q;
              valid_o <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lpc_uart_device.sv
// lpc_uart_device: LPC I/O slave with a minimal 16550-style UART.
//   lpc_clk           : LPC clock, all logic on its rising edge
//   lpc_rst           : asynchronous active-low reset
//   lpc_data0..3      : LAD[3:0], driven only during SYNC/read data
//   lpc_frame         : LFRAME#, active-low; low always restarts decode
//   uart_tx / uart_rx : serial pins, idle high
// Registers: BASE_ADDR+0 data (read pops RX FIFO, write loads TX slot),
// BASE_ADDR+5 LSR (read-only, writes claimed and ignored).
// Build option: define SCRATCH_REG_EN to add a read/write scratch register
// at BASE_ADDR+7; without it that address is not claimed.
module lpc_uart_device
  import lpc_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h03F8,
  parameter int          BAUD_DIV  = 286,
  parameter int          RX_DEPTH  = 4
) (
  input  logic lpc_clk,
  input  logic lpc_rst,
  inout  wire  lpc_data0,
  inout  wire  lpc_data1,
  inout  wire  lpc_data2,
  inout  wire  lpc_data3,
  input  logic lpc_frame,
  output logic uart_tx,
  input  logic uart_rx
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = $clog2(RX_DEPTH + 1);

  // ---------------- LAD pins ----------------
  logic       lad_oe_q;
  logic [3:0] lad_out_q;
  logic [3:0] lad_in;

  assign lad_in    = {lpc_data3, lpc_data2, lpc_data1, lpc_data0};
  assign lpc_data0 = lad_oe_q ? lad_out_q[0] : 1'bz;
  assign lpc_data1 = lad_oe_q ? lad_out_q[1] : 1'bz;
  assign lpc_data2 = lad_oe_q ? lad_out_q[2] : 1'bz;
  assign lpc_data3 = lad_oe_q ? lad_out_q[3] : 1'bz;

  // ---------------- LPC FSM state ----------------
  lpc_state_e  state_q;
  logic [1:0]  cnt_q;
  logic        dir_wr_q;
  logic [11:0] addr_q;
  logic [2:0]  reg_q;
  logic [3:0]  wlo_q;
  logic [7:0]  rdata_q;

  logic [15:0] addr_ofs;
  logic        addr_hit;
  logic        rd_latch, wr_commit;
  logic [7:0]  wdata, rd_mux;

  // Offset of the address completed by the current (last) address nibble.
  assign addr_ofs = {addr_q, lad_in} - BASE_ADDR;

  always_comb begin
    addr_hit = (addr_ofs == 16'(OFS_DATA)) || (addr_ofs == 16'(OFS_LSR));
`ifdef SCRATCH_REG_EN
    if (addr_ofs == 16'(OFS_SCR)) addr_hit = 1'b1;
`endif
  end

  // Read data is captured on the second TAR edge; writes commit on the
  // high-nibble edge. A low LFRAME# on that edge aborts both.
  assign rd_latch  = lpc_frame && (state_q == TAR) && (cnt_q == 2'd1) && !dir_wr_q;
  assign wr_commit = lpc_frame && (state_q == WDATA) && (cnt_q == 2'd1);
  assign wdata     = {lad_in, wlo_q};

  // ---------------- RX FIFO / TX slot signals ----------------
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [7:0]    fifo_head, rx_data;
  logic          rx_valid;

  logic [10:0]   tx_shift_q;
  logic [BW-1:0] tx_baud_q;
  logic [3:0]    tx_bits_q;
  logic          tx_busy_q, tx_load;

`ifdef SCRATCH_REG_EN
  logic [7:0] scr_q;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(RX_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign fifo_pop   = rd_latch && (reg_q == OFS_DATA) && !fifo_empty;
  // A pop in the same cycle frees the slot the push writes into.
  assign fifo_push  = rx_valid && (!fifo_full || fifo_pop);
  assign tx_load    = wr_commit && (reg_q == OFS_DATA) && !tx_busy_q;

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    rd_mux = 8'h00;
    case (reg_q)
      OFS_DATA: rd_mux = fifo_empty ? 8'hFF : fifo_head;
      OFS_LSR:  rd_mux = lsr_value(!fifo_empty, !tx_busy_q);
`ifdef SCRATCH_REG_EN
      OFS_SCR:  rd_mux = scr_q;
`endif
      default:  rd_mux = 8'h00;
    endcase
  end

  // ---------------- LPC cycle FSM ----------------
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_wr_q  <= 1'b0;
      addr_q    <= '0;
      reg_q     <= '0;
      wlo_q     <= '0;
      rdata_q   <= '0;
      lad_oe_q  <= 1'b0;
      lad_out_q <= '0;
    end else if (!lpc_frame) begin
      lad_oe_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= (lad_in == LAD_START) ? CTDIR : IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        CTDIR: begin
          if (lad_in == CTDIR_IORD || lad_in == CTDIR_IOWR) begin
            dir_wr_q <= (lad_in == CTDIR_IOWR);
            cnt_q    <= '0;
            state_q  <= ADDR;
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          addr_q <= {addr_q[7:0], lad_in};
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_q   <= '0;
            reg_q   <= addr_ofs[2:0];
            state_q <= !addr_hit ? IDLE : (dir_wr_q ? WDATA : TAR);
          end
        end
        WDATA: begin
          if (cnt_q == 2'd0) begin
            wlo_q <= lad_in;
            cnt_q <= 2'd1;
          end else begin
            cnt_q   <= '0;
            state_q <= TAR;
          end
        end
        TAR: begin
          if (cnt_q == 2'd0) begin
            cnt_q <= 2'd1;
          end else begin
            cnt_q     <= '0;
            if (rd_latch) rdata_q <= rd_mux;
            lad_oe_q  <= 1'b1;
            lad_out_q <= SYNC_READY;
            state_q   <= SYNC;
          end
        end
        SYNC: begin
          if (dir_wr_q) begin
            lad_oe_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            lad_out_q <= rdata_q[3:0];
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (cnt_q == 2'd0) begin
            lad_out_q <= rdata_q[7:4];
            cnt_q     <= 2'd1;
          end else begin
            lad_oe_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCRATCH_REG_EN
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst)                              scr_q <= 8'h00;
    else if (wr_commit && reg_q == OFS_SCR)    scr_q <= wdata;
  end
`endif

  // ---------------- TX: single slot, 8N2 ----------------
  // The shifter idles all-ones, so bit 0 drives the pin directly.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
    end else if (tx_load) begin
      tx_shift_q <= {2'b11, wdata, 1'b0};
      tx_baud_q  <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BW'(BAUD_DIV - 1)) begin
        tx_baud_q  <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[10:1]};
        if (tx_bits_q == 4'd10) tx_busy_q <= 1'b0;
        else                    tx_bits_q <= tx_bits_q + 4'd1;
      end else begin
        tx_baud_q <= tx_baud_q + 1'b1;
      end
    end
  end

  assign uart_tx = tx_shift_q[0];

  // ---------------- RX path and FIFO ----------------
  lpc_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (lpc_clk),
    .rst_n   (lpc_rst),
    .rx_i    (uart_rx),
    .data_o  (rx_data),
    .valid_o (rx_valid)
  );

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RX_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge lpc_clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_lpc_uart_device.sv
// tb_lpc_uart_device: directed, self-checking bench for lpc_uart_device.
// Expected RX bytes and TX frames go into scoreboard queues when stimulus is
// driven and are popped when the DUT returns data (LPC read or TX pin frame).
// Define SCRATCH_REG_EN to exercise the optional scratch register.
module tb_lpc_uart_device;
  import lpc_uart_pkg::*;

  localparam logic [15:0] BASE  = 16'h03F8;
  localparam int          BAUD  = 286;
  localparam int          DEPTH = 4;

  logic       lpc_clk = 1'b0;
  logic       lpc_rst;
  logic       lpc_frame;
  logic       uart_rx;
  logic       uart_tx;
  logic       tb_oe;
  logic [3:0] lad_drv;
  wire  [3:0] lad;

  int n_tests = 0;
  int n_fail  = 0;
  bit dut_drove;

  logic [7:0]  rx_exp [$];
  logic [10:0] tx_exp [$];
  logic [10:0] tx_seen [$];

  // LAD has board pull-ups: a released bus reads 4'hF.
  pullup (lad[0]);
  pullup (lad[1]);
  pullup (lad[2]);
  pullup (lad[3]);
  assign lad = tb_oe ? lad_drv : 4'bzzzz;

  always #15 lpc_clk = ~lpc_clk;

  lpc_uart_device #(.BASE_ADDR(BASE), .BAUD_DIV(BAUD), .RX_DEPTH(DEPTH)) dut (
    .lpc_clk   (lpc_clk),
    .lpc_rst   (lpc_rst),
    .lpc_data0 (lad[0]),
    .lpc_data1 (lad[1]),
    .lpc_data2 (lad[2]),
    .lpc_data3 (lad[3]),
    .lpc_frame (lpc_frame),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  // Any non-idle LAD value while the host is not driving is the device.
  always @(posedge lpc_clk) if (!tb_oe && lad !== 4'hF) dut_drove = 1'b1;

  // TX pin capture: 11 mid-bit samples per frame, first bit in bit 0.
  initial begin
    logic [10:0] f;
    forever begin
      @(negedge uart_tx);
      repeat (BAUD / 2) @(negedge lpc_clk);
      for (int i = 0; i < 11; i++) begin
        f[i] = uart_tx;
        if (i < 10) repeat (BAUD) @(negedge lpc_clk);
      end
      tx_seen.push_back(f);
    end
  end

  initial begin
    #(30 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LPC I/O cycle, inputs driven on falling edges. When claim is set the
  // SYNC, data and release nibbles are checked; otherwise the device must
  // never drive LAD.
  task automatic lpc_cycle(input logic [3:0] ctdir, input logic [15:0] addr,
                           input logic [7:0] wdata, input bit claim,
                           input string tag, output logic [7:0] rdata);
    logic [3:0] lo, hi;
    rdata = 8'h00;
    @(negedge lpc_clk); dut_drove = 1'b0; lpc_frame = 1'b0; lad_drv = LAD_START; tb_oe = 1'b1;
    @(negedge lpc_clk); lpc_frame = 1'b1; lad_drv = ctdir;
    for (int i = 3; i >= 0; i--) begin
      @(negedge lpc_clk); lad_drv = addr[i*4 +: 4];
    end
    if (ctdir == CTDIR_IOWR) begin
      @(negedge lpc_clk); lad_drv = wdata[3:0];
      @(negedge lpc_clk); lad_drv = wdata[7:4];
      @(negedge lpc_clk); tb_oe = 1'b0;
      @(negedge lpc_clk);
      @(negedge lpc_clk); if (claim) check({tag, "_sync"}, 16'(lad), 16'(SYNC_READY));
      @(negedge lpc_clk); if (claim) check({tag, "_rel"}, 16'(lad), 16'hF);
    end else begin
      @(negedge lpc_clk); tb_oe = 1'b0;
      @(negedge lpc_clk);
      @(negedge lpc_clk); if (claim) check({tag, "_sync"}, 16'(lad), 16'(SYNC_READY));
      @(negedge lpc_clk); lo = lad;
      @(negedge lpc_clk); hi = lad;
      @(negedge lpc_clk); if (claim) check({tag, "_rel"}, 16'(lad), 16'hF);
      rdata = {hi, lo};
    end
    if (!claim) check({tag, "_nodrive"}, 16'(dut_drove), 16'h0);
  endtask

  task automatic read_lsr(input logic [7:0] exp, input string tag);
    logic [7:0] r;
    lpc_cycle(CTDIR_IORD, BASE + 16'd5, 8'h00, 1'b1, tag, r);
    check(tag, 16'(r), 16'(exp));
  endtask

  task automatic read_data(input string tag);
    logic [7:0] r, e;
    lpc_cycle(CTDIR_IORD, BASE, 8'h00, 1'b1, tag, r);
    e = 8'hFF;
    if (rx_exp.size() != 0) e = rx_exp.pop_front();
    check(tag, 16'(r), 16'(e));
  endtask

  task automatic lpc_write(input logic [15:0] addr, input logic [7:0] d, input bit claim, input string tag);
    logic [7:0] unused;
    lpc_cycle(CTDIR_IOWR, addr, d, claim, tag, unused);
  endtask

  // 8N1 frame on uart_rx; the model keeps a byte only if the FIFO has room.
  task automatic uart_send(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge lpc_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BAUD) @(negedge lpc_clk);
    end
    uart_rx = 1'b1;
    repeat (BAUD) @(negedge lpc_clk);
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
  endtask

  task automatic check_tx(input string tag);
    logic [15:0] obs, exp;
    exp = 16'h0;
    if (tx_exp.size() != 0) exp = 16'(tx_exp.pop_front());
    obs = 16'hFFFF;
    if (tx_seen.size() != 0) obs = 16'(tx_seen.pop_front());
    check(tag, obs, exp);
  endtask

  initial begin
    logic [7:0] r;
    lpc_rst   = 1'b0;
    lpc_frame = 1'b1;
    tb_oe     = 1'b0;
    lad_drv   = 4'h0;
    uart_rx   = 1'b1;
    repeat (3) @(negedge lpc_clk);
    check("rst_uart_tx", 16'(uart_tx), 16'h1);
    check("rst_lad", 16'(lad), 16'hF);
    lpc_rst = 1'b1;
    repeat (3) @(negedge lpc_clk);

    // Reset state
    read_lsr(8'h60, "rst_lsr");
    read_data("rst_data_empty");

    // Single received byte, then empty reads
    uart_send(8'h5A);
    read_lsr(8'h61, "rx5a_lsr");
    read_data("rx5a_data");
    read_lsr(8'h60, "rx5a_lsr_after");
    for (int i = 0; i < 3; i++) begin
      read_data("empty_data");
      read_lsr(8'h60, "empty_lsr");
    end

    // Transmit 0x5A; a second write while busy is dropped
    lpc_write(BASE, 8'h5A, 1'b1, "tx5a_wr");
    tx_exp.push_back({2'b11, 8'h5A, 1'b0});
    read_lsr(8'h00, "tx5a_lsr_busy");
    lpc_write(BASE, 8'hC3, 1'b1, "tx_drop_wr");
    repeat (2000) @(negedge lpc_clk);
    read_lsr(8'h00, "tx5a_lsr_2000");
    repeat (2000) @(negedge lpc_clk);
    read_lsr(8'h60, "tx5a_lsr_4000");
    check_tx("tx5a_frame");
    check("tx_busy_drop", 16'(tx_seen.size()), 16'h0);

    // TX and RX concurrently
    lpc_write(BASE, 8'hA5, 1'b1, "txa5_wr");
    tx_exp.push_back({2'b11, 8'hA5, 1'b0});
    uart_send(8'h0F);
    read_lsr(8'h01, "both_lsr_busy");
    repeat (4000) @(negedge lpc_clk);
    read_lsr(8'h61, "both_lsr_idle");
    read_data("both_data");
    read_lsr(8'h60, "both_lsr_empty");
    check_tx("txa5_frame");

    // Back-to-back reception
    uart_send(8'h01); repeat (10) @(negedge lpc_clk);
    uart_send(8'h02); repeat (10) @(negedge lpc_clk);
    uart_send(8'h03); repeat (10) @(negedge lpc_clk);
    for (int i = 0; i < 3; i++) begin
      read_lsr(8'h61, "b2b_lsr");
      read_data("b2b_data");
    end
    read_lsr(8'h60, "b2b_lsr_empty");
    read_data("b2b_data_empty");

    // Overflow: five bytes into a four-entry FIFO keep the first four
    for (int i = 0; i < 5; i++) begin
      uart_send(8'h10 + 8'(i));
      repeat (10) @(negedge lpc_clk);
    end
    for (int i = 0; i < 5; i++) read_data("ovf_data");
    read_lsr(8'h60, "ovf_lsr_empty");

    // LSR write is claimed and ignored
    lpc_write(BASE + 16'd5, 8'hFF, 1'b1, "lsr_wr");
    read_lsr(8'h60, "lsr_wr_ignored");

    // Undecoded address and unsupported cycle type
    lpc_cycle(CTDIR_IORD, 16'h02F8, 8'h00, 1'b0, "undec_rd", r);
    lpc_write(16'h02F8, 8'h77, 1'b0, "undec_wr");
    lpc_cycle(4'h4, BASE, 8'h00, 1'b0, "ctdir4", r);
    read_lsr(8'h60, "undec_lsr");

`ifdef SCRATCH_REG_EN
    lpc_cycle(CTDIR_IORD, BASE + 16'd7, 8'h00, 1'b1, "scr_rst", r);
    check("scr_rst", 16'(r), 16'h00);
    lpc_write(BASE + 16'd7, 8'hA7, 1'b1, "scr_wr");
    lpc_cycle(CTDIR_IORD, BASE + 16'd7, 8'h00, 1'b1, "scr_rd", r);
    check("scr_rd", 16'(r), 16'hA7);
`else
    lpc_cycle(CTDIR_IORD, BASE + 16'd7, 8'h00, 1'b0, "scr_absent_rd", r);
    lpc_write(BASE + 16'd7, 8'hA7, 1'b0, "scr_absent_wr");
`endif

    // Reset in the middle of a reception clears a non-empty FIFO
    uart_send(8'h77);
    uart_rx = 1'b0;
    repeat (3 * BAUD) @(negedge lpc_clk);
    lpc_rst = 1'b0;
    repeat (3) @(negedge lpc_clk);
    uart_rx = 1'b1;
    lpc_rst = 1'b1;
    rx_exp.delete();
    repeat (3500) @(negedge lpc_clk);
    check("midrx_uart_tx", 16'(uart_tx), 16'h1);
    read_lsr(8'h60, "midrx_lsr");
    read_data("midrx_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_uart_device.md
Name: lpc_uart_device

Overview:
- LPC-bus slave exposing a minimal 16550-style UART: a data register at I/O base+0 and a Line Status Register at base+5.
- Runs entirely on the 33 MHz LPC clock and drives physical uart_tx/uart_rx pins at a fixed baud divisor.
- TX is a single holding slot; RX is a small FIFO.

Parameters:
- BASE_ADDR, 16'h03F8, I/O base; decoded ports are BASE_ADDR (data) and BASE_ADDR+5 (LSR).
- BAUD_DIV, 286, lpc_clk cycles per UART bit (33 MHz / 115200).
- RX_DEPTH, 4, RX FIFO entries (minimum 3).

Ports:
- lpc_clk  input  1  LPC clock; all logic on its rising edge.
- lpc_rst  input  1  reset, asynchronous, active-low.
- lpc_data0..lpc_data3  inout  1 each  LAD[3:0]; tri-stated unless the device drives.
- lpc_frame  input  1  LFRAME#, active-low.
- uart_tx  output  1  serial out, idle high.
- uart_rx  input  1  serial in, idle high; 2-flop synchronised internally.

Behaviour:
- Reset: LAD released (hi-Z), uart_tx=1, RX FIFO empty, TX idle, LPC FSM in IDLE.
- LPC cycle, in rising edges E1..:
  - E1: lpc_frame=0 with LAD=0000 is START. lpc_frame=0 at any time aborts the current cycle and re-evaluates START.
  - E2: CTDIR; 0000 = I/O read, 0010 = I/O write. Any other value returns the FSM to IDLE.
  - E3..E6: address nibbles, MSB first.
  - Address not decoded: the device never drives LAD and waits for the next START.
- I/O read timing:
  - E7: host TAR; device hi-Z.
  - After E8: drive SYNC 0000.
  - After E9: drive data[3:0].
  - After E10: drive data[7:4].
  - After E11: hi-Z.
  - Read data is latched at E8.
- I/O write timing:
  - E7: data[3:0]; E8: data[7:4].
  - E9: TAR; device hi-Z.
  - After E10: drive SYNC 0000.
  - After E11: hi-Z.
  - The write takes effect at E8.
- Data register read: returns the FIFO head and pops it. Empty FIFO returns 8'hFF with no pop.
- Data register write:
  - TX idle: load and start transmission immediately.
  - TX busy: byte is dropped.
- LSR read (no side effects):
  - bit0 DR = FIFO not empty.
  - bit5 THRE and bit6 TEMT = TX idle (both identical).
  - All other bits 0.
  - Values: 0x60 idle/empty, 0x61 idle/data, 0x00 busy/empty, 0x01 busy/data.
- Writes to the LSR are claimed (SYNC given) and ignored.
- TX frame, 8N2, each bit BAUD_DIV cycles: start 0, 8 data bits LSB first, 2 stop bits of 1. Busy from the E8 load until the second stop bit completes (11*BAUD_DIV = 3146 cycles).
- RX path:
  - Falling edge on the synchronised rx arms the receiver.
  - Start bit re-checked at BAUD_DIV/2 cycles; if high, treat as a glitch and return to idle.
  - Data sampled mid-bit, LSB first. Stop bit sampled mid-bit.
  - Stop=1: push the byte. Stop=0: discard (framing error).
  - Return to idle immediately after sampling the stop bit, so back-to-back frames are accepted.
- FIFO:
  - Full: the new byte is dropped and the contents are unchanged.
  - Simultaneous push and pop in one cycle is legal: count unchanged, order preserved.
  - Pointers wrap modulo RX_DEPTH.
- RX and TX are fully independent.

Optional Feature:
- SCRATCH_REG_EN defined: 8-bit scratch register at BASE_ADDR+7, read/write, reset 8'h00.
- Undefined: BASE_ADDR+7 is not decoded; no SYNC is driven.

Decomposition:
- Package lpc_uart_pkg:
  - Register offsets (DATA=0, LSR=5, SCR=7).
  - CTDIR codes (IORD=4'h0, IOWR=4'h2).
  - SYNC_READY=4'h0.
  - LSR bit indices.
  - LPC FSM state enum: IDLE, CTDIR, ADDR, WDATA, TAR, SYNC, RDATA.
- One sub-module: lpc_uart_rx, covering the bit-level receiver (synchroniser, mid-bit sampler, byte-valid strobe).
- FIFO, TX shifter and LPC FSM stay in the top module.

Test Plan:
- After reset: LSR read = 0x60; data read = 0xFF.
- UART-in 0x5A: LSR = 0x61; data read = 0x5A; then LSR = 0x60; three further empty reads each return 0xFF with LSR = 0x60.
- LPC write 0x5A to 0x3F8: immediate LSR = 0x00; still 0x00 after 2000 cycles; 0x60 after 4000 cycles; uart_tx shows 0,0,1,0,1,1,0,1,0,1,1 at BAUD_DIV spacing.
- Write 0xA5, then receive 0x0F on RX during TX: LSR = 0x01; after 4000 cycles LSR = 0x61; data = 0x0F; then LSR = 0x60.
- Receive 0x01, 0x02, 0x03 back-to-back (10-cycle gaps): three reads return 01, 02, 03 with LSR = 0x61 before each; then LSR = 0x60 and data = 0xFF. Five bytes into depth 4 keeps the first four.
- Access to 0x2F8, or a CTDIR of 0x4: LAD never driven. Assert lpc_rst mid-RX: FIFO empty and LSR = 0x60 after release.
